// File: rtl/spi_dcs_slave.sv
// spi_dcs_slave
//   Dual-chip-select SPI slave front end (mode 0, MSB first). An address frame
//   arrives under spi_cs_addr and a data frame under spi_cs_data. Every SPI pin
//   is oversampled in the clk domain, so clk must run at least 8x spi_scl.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   spi_scl       SPI clock input
//   spi_sdi       MOSI input
//   spi_sdo       MISO output, driven only while a data frame is active
//   spi_cs_addr   address-frame select, active-low
//   spi_cs_data   data-frame select, active-low
//   Din           readback word, sampled in the Data_begin cycle
//   Addr          last complete address, held
//   Dout          last complete data word, held
//   Data_begin    1-cycle pulse at data-frame start
//   Data_end      1-cycle pulse at valid data-frame end (Dout and Addr valid)
//   frame_err     1-cycle pulse on a malformed or overlapped frame
module spi_dcs_slave #(
    parameter int WIDTH_ADDR = 8,
    parameter int WIDTH_DATA = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_scl,
    input  logic                  spi_sdi,
    output logic                  spi_sdo,
    input  logic                  spi_cs_addr,
    input  logic                  spi_cs_data,
    input  logic [WIDTH_DATA-1:0] Din,
    output logic [WIDTH_ADDR-1:0] Addr,
    output logic [WIDTH_DATA-1:0] Dout,
    output logic                  Data_begin,
    output logic                  Data_end,
    output logic                  frame_err
);

    localparam int MAX_W = (WIDTH_ADDR > WIDTH_DATA) ? WIDTH_ADDR : WIDTH_DATA;
    localparam int CNT_W = $clog2(MAX_W + 2);

    localparam logic [CNT_W-1:0] ADDR_FULL = CNT_W'(WIDTH_ADDR);
    localparam logic [CNT_W-1:0] ADDR_SAT  = CNT_W'(WIDTH_ADDR + 1);
    localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(WIDTH_DATA);
    localparam logic [CNT_W-1:0] DATA_SAT  = CNT_W'(WIDTH_DATA + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state_q;
    logic [2:0]              scl_sync_q;
    logic [2:0]              csa_sync_q;
    logic [2:0]              csd_sync_q;
    // sdi needs no edge detect; its stage 1 lines up with the scl edge stage.
    logic [1:0]              sdi_sync_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [WIDTH_ADDR-1:0]   addr_shift_q;
    logic [WIDTH_DATA-1:0]   rx_shift_q;
    logic [WIDTH_DATA-1:0]   tx_shift_q;
    logic [WIDTH_ADDR-1:0]   addr_q;
    logic [WIDTH_DATA-1:0]   dout_q;
    logic                    begin_q;
    logic                    end_q;
    logic                    err_q;
    // Set when the data select falls during an address frame; that data frame
    // is then dropped and the address frame reports an error.
    logic                    overlap_q;

    logic scl_rise, scl_fall, csa_fall, csa_rise, csd_fall, csd_rise, sdi_s;

    always_comb begin
        scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
        scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
        csa_fall = ~csa_sync_q[1] & csa_sync_q[2];
        csa_rise = csa_sync_q[1] & ~csa_sync_q[2];
        csd_fall = ~csd_sync_q[1] & csd_sync_q[2];
        csd_rise = csd_sync_q[1] & ~csd_sync_q[2];
        sdi_s    = sdi_sync_q[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            // cs stages reset to "asserted" so a frame in flight at release is
            // never seen as starting; only its trailing rise is observed.
            scl_sync_q   <= '0;
            csa_sync_q   <= '0;
            csd_sync_q   <= '0;
            sdi_sync_q   <= '0;
            bit_cnt_q    <= '0;
            addr_shift_q <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            begin_q      <= 1'b0;
            end_q        <= 1'b0;
            err_q        <= 1'b0;
            overlap_q    <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], spi_scl};
            csa_sync_q <= {csa_sync_q[1:0], spi_cs_addr};
            csd_sync_q <= {csd_sync_q[1:0], spi_cs_data};
            sdi_sync_q <= {sdi_sync_q[0], spi_sdi};
            begin_q    <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (csa_fall) begin
                        state_q   <= ADDR;
                        bit_cnt_q <= '0;
                        overlap_q <= 1'b0;
                    end else if (csd_fall) begin
                        state_q    <= DATA;
                        bit_cnt_q  <= '0;
                        begin_q    <= 1'b1;
                        rx_shift_q <= '0;
                        tx_shift_q <= '0;
                    end
                end

                ADDR: begin
                    if (csd_fall) begin
                        overlap_q <= 1'b1;
                    end
                    if (scl_rise) begin
                        addr_shift_q <= {addr_shift_q[WIDTH_ADDR-2:0], sdi_s};
                        if (bit_cnt_q != ADDR_SAT) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    if (csa_rise) begin
                        state_q <= IDLE;
                        if (bit_cnt_q == ADDR_FULL) begin
                            addr_q <= addr_shift_q;
                        end
                        if ((bit_cnt_q != ADDR_FULL) || overlap_q || csd_fall) begin
                            err_q <= 1'b1;
                        end
                    end
                end

                DATA: begin
                    // Din is captured while Data_begin is high, so the MSB is
                    // on spi_sdo one cycle later, well before the first scl rise.
                    if (begin_q) begin
                        tx_shift_q <= Din;
                    end else if (scl_fall) begin
                        tx_shift_q <= {tx_shift_q[WIDTH_DATA-2:0], 1'b0};
                    end
                    if (scl_rise) begin
                        rx_shift_q <= {rx_shift_q[WIDTH_DATA-2:0], sdi_s};
                        if (bit_cnt_q != DATA_SAT) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    if (csd_rise) begin
                        state_q <= IDLE;
                        if (bit_cnt_q == DATA_FULL) begin
                            dout_q <= rx_shift_q;
                            end_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign spi_sdo    = (state_q == DATA) ? tx_shift_q[WIDTH_DATA-1] : 1'b0;
    assign Addr       = addr_q;
    assign Dout       = dout_q;
    assign Data_begin = begin_q;
    assign Data_end   = end_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_dcs_slave.sv
module tb_spi_dcs_slave;

    logic        clk;
    logic        rst;
    logic        spi_scl;
    logic        spi_sdi;
    logic        spi_sdo;
    logic        spi_cs_addr;
    logic        spi_cs_data;
    logic [15:0] Din;
    logic [7:0]  Addr;
    logic [15:0] Dout;
    logic        Data_begin;
    logic        Data_end;
    logic        frame_err;

    int checks = 0;
    int fails  = 0;
    int n_begin = 0;
    int n_end   = 0;
    int n_err   = 0;
    logic [15:0] end_dout[$];
    logic [7:0]  end_addr[$];

    spi_dcs_slave #(.WIDTH_ADDR(8), .WIDTH_DATA(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_scl     (spi_scl),
        .spi_sdi     (spi_sdi),
        .spi_sdo     (spi_sdo),
        .spi_cs_addr (spi_cs_addr),
        .spi_cs_data (spi_cs_data),
        .Din         (Din),
        .Addr        (Addr),
        .Dout        (Dout),
        .Data_begin  (Data_begin),
        .Data_end    (Data_end),
        .frame_err   (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor, sampled on the inactive clock edge.
    always @(negedge clk) begin
        if (Data_begin) n_begin++;
        if (frame_err)  n_err++;
        if (Data_end) begin
            n_end++;
            end_dout.push_back(Dout);
            end_addr.push_back(Addr);
        end
    end

    // Shift n bits MSB first in mode 0; MISO is sampled at each scl rise.
    task automatic send_bits(input logic [15:0] val, input int n, output logic [15:0] miso);
        miso = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_sdi = val[i];
            #40;
            spi_scl = 1'b1;
            miso = {miso[14:0], spi_sdo};
            #40;
            spi_scl = 1'b0;
        end
    endtask

    task automatic addr_frame(input logic [7:0] val, input int n);
        logic [15:0] unused_miso;
        spi_cs_addr = 1'b0;
        #100;
        send_bits({8'h00, val}, n, unused_miso);
        #40;
        spi_cs_addr = 1'b1;
        #100;
    endtask

    task automatic data_frame(input logic [15:0] val, input int n, output logic [15:0] miso);
        spi_cs_data = 1'b0;
        #100;
        send_bits(val, n, miso);
        #40;
        spi_cs_data = 1'b1;
        #100;
    endtask

    task automatic test_reset;
        checks++; if (Addr !== 8'h00) begin fails++; $display("FAIL reset_addr got %h want %h", Addr, 8'h00); end
        checks++; if (Dout !== 16'h0000) begin fails++; $display("FAIL reset_dout got %h want %h", Dout, 16'h0000); end
        checks++; if (spi_sdo !== 1'b0) begin fails++; $display("FAIL reset_sdo got %b want 0", spi_sdo); end
        checks++; if ({Data_begin, Data_end, frame_err} !== 3'b000) begin
            fails++; $display("FAIL reset_pulses got %b want 000", {Data_begin, Data_end, frame_err});
        end
    endtask

    task automatic test_readback;
        int b0, e0;
        logic [15:0] miso;
        addr_frame(8'h81, 8);
        b0 = n_begin; e0 = n_end;
        Din = 16'h1234;
        data_frame(16'h0000, 16, miso);
        checks++; if (Addr !== 8'h81) begin fails++; $display("FAIL rb_addr got %h want %h", Addr, 8'h81); end
        checks++; if (miso !== 16'h1234) begin fails++; $display("FAIL rb_miso got %h want %h", miso, 16'h1234); end
        checks++; if (n_begin - b0 !== 1) begin fails++; $display("FAIL rb_begin_cnt got %0d want 1", n_begin - b0); end
        checks++; if (n_end - e0 !== 1) begin fails++; $display("FAIL rb_end_cnt got %0d want 1", n_end - e0); end
    endtask

    task automatic test_write;
        int e0;
        logic [15:0] miso;
        addr_frame(8'h01, 8);
        end_dout.delete(); end_addr.delete();
        e0 = n_end;
        data_frame(16'hBEEF, 16, miso);
        checks++; if (n_end - e0 !== 1) begin fails++; $display("FAIL wr_end_cnt got %0d want 1", n_end - e0); end
        if (end_dout.size() > 0) begin
            checks++; if (end_dout[0] !== 16'hBEEF) begin fails++; $display("FAIL wr_dout_at_end got %h want %h", end_dout[0], 16'hBEEF); end
            checks++; if (end_addr[0] !== 8'h01) begin fails++; $display("FAIL wr_addr_at_end got %h want %h", end_addr[0], 8'h01); end
        end
        #200;
        checks++; if (Dout !== 16'hBEEF) begin fails++; $display("FAIL wr_dout_hold got %h want %h", Dout, 16'hBEEF); end
    endtask

    task automatic test_back_to_back;
        int b0, e0;
        logic [15:0] miso;
        logic [15:0] exp_d[3];
        exp_d[0] = 16'h0001; exp_d[1] = 16'h0002; exp_d[2] = 16'h0003;
        addr_frame(8'h04, 8);
        end_dout.delete(); end_addr.delete();
        b0 = n_begin; e0 = n_end;
        for (int k = 0; k < 3; k++) data_frame(exp_d[k], 16, miso);
        checks++; if (n_begin - b0 !== 3) begin fails++; $display("FAIL b2b_begin_cnt got %0d want 3", n_begin - b0); end
        checks++; if (n_end - e0 !== 3) begin fails++; $display("FAIL b2b_end_cnt got %0d want 3", n_end - e0); end
        for (int k = 0; k < 3; k++) begin
            if (k < end_dout.size()) begin
                checks++; if (end_dout[k] !== exp_d[k]) begin fails++; $display("FAIL b2b_dout%0d got %h want %h", k, end_dout[k], exp_d[k]); end
                checks++; if (end_addr[k] !== 8'h04) begin fails++; $display("FAIL b2b_addr%0d got %h want %h", k, end_addr[k], 8'h04); end
            end
        end
    endtask

    task automatic test_short;
        int e0, r0;
        logic [15:0] miso;
        e0 = n_end; r0 = n_err;
        addr_frame(8'h55, 7);
        data_frame(16'h7777, 15, miso);
        checks++; if (Addr !== 8'h04) begin fails++; $display("FAIL short_addr got %h want %h", Addr, 8'h04); end
        checks++; if (Dout !== 16'h0003) begin fails++; $display("FAIL short_dout got %h want %h", Dout, 16'h0003); end
        checks++; if (n_end - e0 !== 0) begin fails++; $display("FAIL short_end_cnt got %0d want 0", n_end - e0); end
        checks++; if (n_err - r0 !== 2) begin fails++; $display("FAIL short_err_cnt got %0d want 2", n_err - r0); end
    endtask

    task automatic test_overlap;
        int b0, e0, r0;
        logic [15:0] miso;
        b0 = n_begin; e0 = n_end; r0 = n_err;
        spi_cs_addr = 1'b0;
        #100;
        spi_cs_data = 1'b0;
        #100;
        send_bits(16'h003C, 8, miso);
        #40;
        spi_cs_addr = 1'b1;
        #100;
        spi_cs_data = 1'b1;
        #100;
        checks++; if (n_begin - b0 !== 0) begin fails++; $display("FAIL ovl_begin_cnt got %0d want 0", n_begin - b0); end
        checks++; if (n_end - e0 !== 0) begin fails++; $display("FAIL ovl_end_cnt got %0d want 0", n_end - e0); end
        checks++; if (n_err - r0 !== 1) begin fails++; $display("FAIL ovl_err_cnt got %0d want 1", n_err - r0); end
        checks++; if (Addr !== 8'h3C) begin fails++; $display("FAIL ovl_addr got %h want %h", Addr, 8'h3C); end
    endtask

    task automatic test_reset_midframe;
        int b0, e0;
        logic [15:0] miso;
        spi_cs_data = 1'b0;
        #100;
        send_bits(16'h01FF, 9, miso);
        rst = 1'b1;
        #30;
        checks++; if ({Addr, Dout} !== 24'h0) begin fails++; $display("FAIL rstmid_outputs got %h want 000000", {Addr, Dout}); end
        rst = 1'b0;
        b0 = n_begin; e0 = n_end;
        #100;
        spi_cs_data = 1'b1;
        #100;
        checks++; if (n_begin - b0 !== 0) begin fails++; $display("FAIL rstmid_begin_cnt got %0d want 0", n_begin - b0); end
        checks++; if (n_end - e0 !== 0) begin fails++; $display("FAIL rstmid_end_cnt got %0d want 0", n_end - e0); end
        e0 = n_end;
        data_frame(16'h5A5A, 16, miso);
        checks++; if (n_end - e0 !== 1) begin fails++; $display("FAIL rstmid_next_end_cnt got %0d want 1", n_end - e0); end
        checks++; if (Dout !== 16'h5A5A) begin fails++; $display("FAIL rstmid_next_dout got %h want %h", Dout, 16'h5A5A); end
    endtask

    initial begin
        rst = 1'b1;
        spi_scl = 1'b0;
        spi_sdi = 1'b0;
        spi_cs_addr = 1'b1;
        spi_cs_data = 1'b1;
        Din = 16'h0000;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        test_readback();
        test_write();
        test_back_to_back();
        test_short();
        test_overlap();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
